frame_tx_arbiter: RTL and testbench
===================================

Name: frame_tx_arbiter

Overview:
- Shares the single UART transmit byte path between NUM_SRC response-producing command handlers.
- Arbitrates round-robin and serialises one complete response frame at a time. Frame format: AA 55 CMD LEN_H LEN_L payload[LEN] CHK.
- CHK is the 8-bit sum, mod 256, of CMD, LEN_H, LEN_L and every payload byte. This is the same framing the command parser accepts on the receive side.
- Sits between the handler modules and the UART TX byte interface.

Parameters:
- NUM_SRC, 4, number of requesting handlers (2..8).
- MAX_PAYLOAD_LEN, 256, largest legal LEN. Any larger request is rejected.
- ID_W, 2, width of grant_id. Must satisfy 2**ID_W >= NUM_SRC.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset, applied to all flops.
- src_req  in  NUM_SRC  per-source frame request. Held high until src_done or src_err.
- src_cmd  in  NUM_SRC*8  per-source CMD byte. Source i occupies bits [i*8+7:i*8].
- src_len  in  NUM_SRC*16  per-source payload length LEN.
- src_data  in  NUM_SRC*8  per-source payload byte.
- src_valid  in  NUM_SRC  per-source payload byte valid.
- src_ready  out  NUM_SRC  payload byte accepted. Only the granted bit can be high.
- src_done  out  NUM_SRC  1-cycle pulse when the CHK byte has been accepted by TX.
- src_err  out  NUM_SRC  1-cycle pulse when a request is rejected (LEN > MAX_PAYLOAD_LEN).
- tx_data  out  8  byte to UART TX.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  UART TX accepts the byte. Transfer occurs when tx_valid && tx_ready.
- busy  out  1  high from grant until return to IDLE.
- grant_id  out  ID_W  index of the granted source. Holds its last value when idle.

Behaviour:
- Reset (async): state IDLE; tx_valid=0, tx_data=0, src_ready=0, src_done=0, src_err=0, busy=0, grant_id=0; round-robin pointer=0; checksum=0.
- States: IDLE, HDR0, HDR1, CMD, LENH, LENL, PAYLOAD, CSUM, DONE.
- IDLE, arbitration:
  - Scan src_req starting at the pointer, wrapping; the first set bit wins.
  - On the win: latch cmd and len, set grant_id, busy=1.
  - If len > MAX_PAYLOAD_LEN: pulse src_err[g] for the next cycle, set pointer=g+1 (mod NUM_SRC), stay in IDLE. No tx_valid is emitted.
  - Otherwise go to HDR0.
- HDR0..LENL: drive AA, 55, CMD, LEN_H, LEN_L in that order.
  - tx_valid and tx_data are registered.
  - The first tx_valid (AA) appears exactly 1 cycle after the IDLE cycle that granted.
  - Advance only on a transfer.
  - The checksum register accumulates CMD, LEN_H, LEN_L as each is transferred.
- Output stability: while tx_valid && !tx_ready, tx_data and tx_valid hold unchanged.
- Back-to-back transfers: with tx_ready held high, one byte transfers per cycle, with no bubbles between header bytes.
- PAYLOAD:
  - src_ready[g] = (state==PAYLOAD) && (bytes remaining > 0) && (!tx_valid || tx_ready). This is combinational.
  - An accepted byte (src_valid[g] && src_ready[g]) loads tx_data on the next edge, sets tx_valid, adds to the checksum and decrements the remaining count.
  - A source stalling src_valid inserts tx_valid=0 bubbles.
  - When the count reaches 0 and the last byte transfers, go to CSUM.
  - LEN=0 skips PAYLOAD and goes LENL -> CSUM.
- CSUM: drive the checksum byte. On transfer go to DONE.
- DONE, one cycle:
  - pulse src_done[g]; set pointer=g+1 mod NUM_SRC.
  - busy=0; return to IDLE.
  - Consequence: at least 2 cycles from the last CHK transfer to the next AA.
- Request handling during a frame:
  - src_req changes from the granted source mid-frame are ignored; the frame runs to completion.
  - Requests from other sources wait.
- Payload bytes from non-granted sources are never accepted; their src_ready stays 0.
- Arithmetic:
  - Checksum is 8-bit, wrapping.
  - The remaining count is 16-bit. LEN up to MAX_PAYLOAD_LEN is legal, including exactly 256.
- Reset mid-frame: all outputs return to reset values immediately. The partial frame is abandoned with no done or err pulse, and the next frame starts with a fresh header.

Test Plan:
1. src_req[0], cmd FF, len 0 -> tx bytes AA 55 FF 00 00 FF; src_done[0] pulses once; src_ready stays 0 throughout.
2. src_req[1], cmd 01, len 4, payload DE AD BE EF -> AA 55 01 00 04 DE AD BE EF 3D; first AA 1 cycle after the grant; src_done[1] pulses.
3. src_req 0, 2, 3 raised together, each len 1 -> frames emitted in order 0, 2, 3. Then, with the pointer at 0, raise 2 and 3 together -> 2 is served before 3.
4. Backpressure: tx_ready held low 10 cycles during a header byte and during a payload byte, plus src_valid gapped on payload -> tx_data stable while stalled; byte sequence and CHK identical to scenario 2.
5. src_req[2] with len 0x0101 while src_req[3] (len 0) is pending -> src_err[2] pulses, no tx_valid for source 2, then source 3's frame AA 55 cmd 00 00 cmd is emitted.
6. Reset asserted mid-payload, then released with src_req[0] pending -> tx_valid=0 and busy=0 during reset; then a fresh full frame from source 0; no src_done for the aborted frame.

Source files
------------

// File: rtl/frame_tx_arbiter.sv
// frame_tx_arbiter
//   Round-robin arbiter that shares one UART TX byte stream between NUM_SRC
//   response handlers and serialises one whole frame at a time:
//     AA 55 CMD LEN_H LEN_L payload[LEN] CHK
//   CHK is the 8-bit wrapping sum of CMD, LEN_H, LEN_L and every payload byte.
//
// Ports
//   clk, rst_n  : clock, asynchronous active-low reset
//   src_req     : per-source frame request, held until src_done/src_err
//   src_cmd     : per-source CMD byte   (source i at [i*8 +: 8])
//   src_len     : per-source LEN        (source i at [i*16 +: 16])
//   src_data    : per-source payload byte, src_valid its qualifier
//   src_ready   : payload byte accepted (granted source only, combinational)
//   src_done    : one-cycle pulse after the CHK byte has transferred
//   src_err     : one-cycle pulse when a request with LEN > MAX_PAYLOAD_LEN is rejected
//   tx_data/tx_valid/tx_ready : byte handshake towards the UART transmitter
//   busy        : high from grant until the return to IDLE
//   grant_id    : index of the granted source, holds when idle
module frame_tx_arbiter #(
  parameter int NUM_SRC         = 4,
  parameter int MAX_PAYLOAD_LEN = 256,
  parameter int ID_W            = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_SRC-1:0]    src_req,
  input  logic [NUM_SRC*8-1:0]  src_cmd,
  input  logic [NUM_SRC*16-1:0] src_len,
  input  logic [NUM_SRC*8-1:0]  src_data,
  input  logic [NUM_SRC-1:0]    src_valid,
  output logic [NUM_SRC-1:0]    src_ready,
  output logic [NUM_SRC-1:0]    src_done,
  output logic [NUM_SRC-1:0]    src_err,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic [ID_W-1:0]       grant_id
);

  typedef enum logic [3:0] {
    S_IDLE, S_HDR0, S_HDR1, S_CMD, S_LENH, S_LENL, S_PAYLOAD, S_CSUM, S_DONE
  } state_e;

  localparam logic [16:0] MAX_LEN = 17'(MAX_PAYLOAD_LEN);

  state_e               state_q;
  logic [ID_W-1:0]      grant_q;
  logic [ID_W-1:0]      ptr_q;
  logic [7:0]           cmd_q;
  logic [15:0]          len_q;
  logic [15:0]          rem_q;
  logic [7:0]           csum_q;
  logic [7:0]           tx_data_q;
  logic                 tx_valid_q;
  logic                 busy_q;
  logic [NUM_SRC-1:0]   src_done_q;
  logic [NUM_SRC-1:0]   src_err_q;

  logic                 arb_found;
  logic [ID_W-1:0]      arb_idx;
  logic [NUM_SRC-1:0]   arb_onehot;
  logic [7:0]           win_cmd;
  logic [15:0]          win_len;
  logic [NUM_SRC-1:0]   gnt_onehot;
  logic [7:0]           sel_data;
  logic                 sel_valid;
  logic                 ready_ok;
  logic                 accept;
  logic                 xfer;

  function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] g);
    return (g == ID_W'(NUM_SRC - 1)) ? '0 : g + ID_W'(1);
  endfunction

  // Round-robin scan in two passes: indices at/above the pointer first,
  // then the wrapped-around indices below it.
  always_comb begin
    arb_found  = 1'b0;
    arb_idx    = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (!arb_found && src_req[i] && (ID_W'(i) >= ptr_q)) begin
        arb_found = 1'b1;
        arb_idx   = ID_W'(i);
      end
    end
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (!arb_found && src_req[i] && (ID_W'(i) < ptr_q)) begin
        arb_found = 1'b1;
        arb_idx   = ID_W'(i);
      end
    end

    win_cmd    = '0;
    win_len    = '0;
    arb_onehot = '0;
    sel_data   = '0;
    sel_valid  = 1'b0;
    gnt_onehot = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (arb_idx == ID_W'(i)) begin
        win_cmd       = src_cmd[i*8 +: 8];
        win_len       = src_len[i*16 +: 16];
        arb_onehot[i] = 1'b1;
      end
      if (grant_q == ID_W'(i)) begin
        sel_data      = src_data[i*8 +: 8];
        sel_valid     = src_valid[i];
        gnt_onehot[i] = 1'b1;
      end
    end
  end

  assign xfer      = tx_valid_q && tx_ready;
  assign ready_ok  = (state_q == S_PAYLOAD) && (rem_q != '0) && (!tx_valid_q || tx_ready);
  assign accept    = ready_ok && sel_valid;
  assign src_ready = ready_ok ? gnt_onehot : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      ptr_q      <= '0;
      cmd_q      <= '0;
      len_q      <= '0;
      rem_q      <= '0;
      csum_q     <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      src_done_q <= '0;
      src_err_q  <= '0;
    end else begin
      src_done_q <= '0;
      src_err_q  <= '0;
      unique case (state_q)
        S_IDLE: begin
          // While an error pulse is out the rejected source still holds its
          // request for this cycle; skipping arbitration avoids a second reject.
          if (arb_found && (src_err_q == '0)) begin
            grant_q <= arb_idx;
            cmd_q   <= win_cmd;
            len_q   <= win_len;
            csum_q  <= '0;
            if ({1'b0, win_len} > MAX_LEN) begin
              src_err_q <= arb_onehot;
              ptr_q     <= next_ptr(arb_idx);
            end else begin
              busy_q     <= 1'b1;
              tx_valid_q <= 1'b1;
              tx_data_q  <= 8'hAA;
              state_q    <= S_HDR0;
            end
          end
        end
        S_HDR0: if (xfer) begin
          tx_data_q <= 8'h55;
          state_q   <= S_HDR1;
        end
        S_HDR1: if (xfer) begin
          tx_data_q <= cmd_q;
          state_q   <= S_CMD;
        end
        S_CMD: if (xfer) begin
          csum_q    <= csum_q + cmd_q;
          tx_data_q <= len_q[15:8];
          state_q   <= S_LENH;
        end
        S_LENH: if (xfer) begin
          csum_q    <= csum_q + len_q[15:8];
          tx_data_q <= len_q[7:0];
          state_q   <= S_LENL;
        end
        S_LENL: if (xfer) begin
          csum_q <= csum_q + len_q[7:0];
          if (len_q == '0) begin
            tx_data_q <= csum_q + len_q[7:0];
            state_q   <= S_CSUM;
          end else begin
            tx_valid_q <= 1'b0;
            rem_q      <= len_q;
            state_q    <= S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (accept) begin
            tx_data_q  <= sel_data;
            tx_valid_q <= 1'b1;
            csum_q     <= csum_q + sel_data;
            rem_q      <= rem_q - 16'd1;
          end else if (xfer) begin
            // Last payload byte leaves: the checksum is already complete.
            if (rem_q == '0) begin
              tx_data_q <= csum_q;
              state_q   <= S_CSUM;
            end else begin
              tx_valid_q <= 1'b0;
            end
          end
        end
        S_CSUM: if (xfer) begin
          tx_valid_q <= 1'b0;
          src_done_q <= gnt_onehot;
          state_q    <= S_DONE;
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          ptr_q   <= next_ptr(grant_q);
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;
  assign grant_id = grant_q;
  assign src_done = src_done_q;
  assign src_err  = src_err_q;

endmodule

// File: tb/tb_frame_tx_arbiter.sv
// Directed bench for frame_tx_arbiter: expected TX bytes, done and err
// pulses are queued when a request is issued and compared as the DUT emits them.
module tb_frame_tx_arbiter;
  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    src_req;
  logic [N*8-1:0]  src_cmd;
  logic [N*16-1:0] src_len;
  logic [N*8-1:0]  src_data;
  logic [N-1:0]    src_valid;
  logic [N-1:0]    src_ready;
  logic [N-1:0]    src_done;
  logic [N-1:0]    src_err;
  logic [7:0]      tx_data;
  logic            tx_valid;
  logic            tx_ready;
  logic            busy;
  logic [1:0]      grant_id;

  frame_tx_arbiter #(.NUM_SRC(N), .MAX_PAYLOAD_LEN(256), .ID_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .src_req(src_req), .src_cmd(src_cmd),
    .src_len(src_len), .src_data(src_data), .src_valid(src_valid),
    .src_ready(src_ready), .src_done(src_done), .src_err(src_err),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [7:0] exp_q[$];
  int         done_q[$];
  int         err_q[$];

  logic [7:0] pay_mem[N][16];
  int         pay_len[N];
  int         pay_idx[N];
  int         req_gen[N];
  int         done_gen[N];
  int         last_gen[N];
  logic [7:0] stage[16];
  bit         gap_en;
  int         ready_cycles = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Queue a request: expected bytes/pulses go to the scoreboard, payload to the source model.
  task automatic start_frame(input int s, input logic [7:0] cmd, input logic [15:0] len,
                             input int n, input bit is_err);
    logic [7:0] sum;
    src_cmd[s*8 +: 8]   = cmd;
    src_len[s*16 +: 16] = len;
    if (is_err) begin
      err_q.push_back(s);
      pay_len[s] = 0;
    end else begin
      sum = cmd + len[15:8] + len[7:0];
      exp_q.push_back(8'hAA);
      exp_q.push_back(8'h55);
      exp_q.push_back(cmd);
      exp_q.push_back(len[15:8]);
      exp_q.push_back(len[7:0]);
      for (int k = 0; k < n; k++) begin
        pay_mem[s][k] = stage[k];
        exp_q.push_back(stage[k]);
        sum = sum + stage[k];
      end
      exp_q.push_back(sum);
      done_q.push_back(s);
      pay_len[s] = n;
    end
    req_gen[s]++;
  endtask

  task automatic check_first(input int g);
    @(negedge clk);
    #2;
    check("first_aa_valid", tx_valid, 1);
    check("first_aa_data", tx_data, 8'hAA);
    check("first_aa_busy", busy, 1);
    check("first_aa_grant", grant_id, g);
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 0;
    for (int k = 0; k < 3000 && !ok; k++) begin
      @(negedge clk);
      #3;
      if (exp_q.size() == 0 && done_q.size() == 0 && err_q.size() == 0 &&
          busy == 1'b0 && src_req == '0)
        ok = 1;
    end
    check({tag, "_complete"}, ok, 1);
  endtask

  // Source handler model: presents payload bytes, drops request on done/err.
  initial begin
    int gap_ctr;
    gap_ctr   = 0;
    src_req   = '0;
    src_valid = '0;
    src_data  = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (src_req[i] && pay_idx[i] < pay_len[i] && !(gap_en && (gap_ctr % 3 == 0))) begin
          src_valid[i]       = 1'b1;
          src_data[i*8 +: 8] = pay_mem[i][pay_idx[i]];
        end else begin
          src_valid[i] = 1'b0;
        end
      end
      gap_ctr++;
      #1;
      for (int i = 0; i < N; i++) begin
        if (src_valid[i] && src_ready[i]) pay_idx[i]++;
        if (req_gen[i] != last_gen[i]) begin
          last_gen[i] = req_gen[i];
          pay_idx[i]  = 0;
        end
        if (src_done[i] || src_err[i]) done_gen[i] = req_gen[i];
        src_req[i] = (req_gen[i] != done_gen[i]);
      end
    end
  end

  // Output monitor / scoreboard.
  initial begin
    bit         stalled_prev;
    logic [7:0] prev_data;
    logic [7:0] e;
    int         s;
    stalled_prev = 0;
    prev_data    = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n) begin
        if (stalled_prev) check("stall_hold", {tx_valid, tx_data}, {1'b1, prev_data});
        stalled_prev = tx_valid && !tx_ready;
        prev_data    = tx_data;
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) check("unexpected_byte", {1'b1, tx_data}, 0);
          else begin
            e = exp_q.pop_front();
            check("tx_byte", tx_data, e);
          end
        end
        if (src_done != '0) begin
          if (done_q.size() == 0) check("unexpected_done", src_done, 0);
          else begin
            s = done_q.pop_front();
            check("done_pulse", src_done, 32'(1) << s);
          end
        end
        if (src_err != '0) begin
          if (err_q.size() == 0) check("unexpected_err", src_err, 0);
          else begin
            s = err_q.pop_front();
            check("err_pulse", src_err, 32'(1) << s);
          end
        end
        if (src_ready != '0) begin
          ready_cycles++;
          check("ready_granted_only", src_ready, 32'(1) << grant_id);
        end
      end else begin
        stalled_prev = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int  r0;
    bit  found;
    rst_n    = 1'b0;
    tx_ready = 1'b0;
    src_cmd  = '0;
    src_len  = '0;
    gap_en   = 0;
    repeat (3) @(negedge clk);
    #2;
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_grant", grant_id, 0);
    check("rst_ready", src_ready, 0);
    check("rst_done", src_done, 0);
    check("rst_err", src_err, 0);
    @(negedge clk);
    rst_n    = 1'b1;
    tx_ready = 1'b1;

    // 1: len 0 frame from source 0
    @(negedge clk);
    r0 = ready_cycles;
    start_frame(0, 8'hFF, 16'd0, 0, 0);
    check_first(0);
    wait_idle("t1");
    check("t1_no_ready", ready_cycles - r0, 0);

    // 2: 4-byte payload from source 1
    stage[0] = 8'hDE; stage[1] = 8'hAD; stage[2] = 8'hBE; stage[3] = 8'hEF;
    @(negedge clk);
    start_frame(1, 8'h01, 16'd4, 4, 0);
    check_first(1);
    wait_idle("t2");

    // 3: move pointer to 0, then 0/2/3 together, then 2/3 together
    @(negedge clk);
    start_frame(3, 8'h33, 16'd0, 0, 0);
    wait_idle("t3a");
    @(negedge clk);
    stage[0] = 8'h10; start_frame(0, 8'hA0, 16'd1, 1, 0);
    stage[0] = 8'h12; start_frame(2, 8'hA2, 16'd1, 1, 0);
    stage[0] = 8'h13; start_frame(3, 8'hA3, 16'd1, 1, 0);
    wait_idle("t3b");
    @(negedge clk);
    stage[0] = 8'h22; start_frame(2, 8'hB2, 16'd1, 1, 0);
    stage[0] = 8'h23; start_frame(3, 8'hB3, 16'd1, 1, 0);
    wait_idle("t3c");

    // 4: backpressure on header and payload, gapped source valid
    stage[0] = 8'hDE; stage[1] = 8'hAD; stage[2] = 8'hBE; stage[3] = 8'hEF;
    @(negedge clk);
    tx_ready = 1'b0;
    gap_en   = 1;
    start_frame(1, 8'h01, 16'd4, 4, 0);
    repeat (12) @(negedge clk);
    tx_ready = 1'b1;
    found = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      #2;
      if (tx_valid && tx_data == 8'hDE) found = 1;
    end
    check("t4_payload_seen", found, 1);
    @(negedge clk);
    tx_ready = 1'b0;
    repeat (10) @(negedge clk);
    tx_ready = 1'b1;
    wait_idle("t4");
    gap_en = 0;

    // 5: oversize request rejected, pending source 3 served next
    @(negedge clk);
    start_frame(2, 8'hC2, 16'h0101, 0, 1);
    start_frame(3, 8'h5A, 16'd0, 0, 0);
    wait_idle("t5");
    check("t5_grant_hold", grant_id, 3);

    // 6: reset mid-payload, then fresh frame from source 0
    for (int k = 0; k < 8; k++) stage[k] = 8'h40 + 8'(k);
    @(negedge clk);
    start_frame(0, 8'h77, 16'd8, 8, 0);
    found = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      #2;
      if (exp_q.size() <= 6) found = 1;
    end
    check("t6_midpayload", found, 1);
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    done_q.delete();
    for (int k = 0; k < 3; k++) begin
      #2;
      check("t6_rst_tx_valid", tx_valid, 0);
      check("t6_rst_busy", busy, 0);
      @(negedge clk);
    end
    for (int k = 0; k < 8; k++) stage[k] = 8'h90 + 8'(k);
    start_frame(0, 8'h78, 16'd8, 8, 0);
    @(negedge clk);
    rst_n = 1'b1;
    check_first(0);
    wait_idle("t6");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
